// File: rtl/sim_signature_bist.sv
// LFSR pattern driver and MISR response compactor for screening a combinational
// circuit under test against a golden signature.
module sim_signature_bist #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [15:0]      golden_sig,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] patterns_applied
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FINISH} state_t;

  state_t           state, state_next;
  logic [15:0]      lfsr, lfsr_next, misr_next, out_ext, seed_eff, golden_q;
  logic [CNT_W-1:0] count, applied_next;
  logic             last;

  // LFSR and MISR share x^16+x^14+x^13+x^11+1 (taps 15,13,12,10).
  always_comb begin
    out_ext             = '0;
    out_ext[OUT_W-1:0]  = dut_out;
    seed_eff            = (seed == 16'h0000) ? 16'hACE1 : seed;
    lfsr_next           = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    misr_next           = {signature[14:0],
                           signature[15] ^ signature[13] ^ signature[12] ^ signature[10]} ^ out_ext;
    applied_next        = patterns_applied + CNT_W'(1);
    last                = (applied_next == count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_patterns == '0) ? FINISH : APPLY;
      APPLY:   state_next = abort ? IDLE : CAPTURE;
      CAPTURE: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = FINISH;
        else           state_next = APPLY;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in           <= '0;
      signature        <= '0;
      patterns_applied <= '0;
      pass             <= 1'b0;
      lfsr             <= 16'h0001;
      count            <= '0;
      golden_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr             <= seed_eff;
            count            <= num_patterns;
            golden_q         <= golden_sig;
            signature        <= '0;
            patterns_applied <= '0;
            pass             <= 1'b0;
            dut_in           <= seed_eff[IN_W-1:0];
          end
        end
        APPLY: begin
          if (abort) pass <= 1'b0;
        end
        CAPTURE: begin
          if (abort) begin
            pass <= 1'b0;
          end else begin
            signature        <= misr_next;
            patterns_applied <= applied_next;
            lfsr             <= lfsr_next;
            // The last pattern leaves dut_in untouched; the run ends here.
            if (!last) dut_in <= lfsr_next[IN_W-1:0];
          end
        end
        FINISH: pass <= (signature == golden_q);
        default: ;
      endcase
    end
  end

endmodule
